// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-wait freeze and
// operand forwarding. Define HAZARD_PERF_CNT_EN to add stall/flush performance counters.

module hazard_fwd_sel (
  input  logic [3:0] ra,
  input  logic [3:0] ex_mem_wa,
  input  logic       ex_mem_reg_write,
  input  logic [3:0] mem_wb_wa,
  input  logic       mem_wb_reg_write,
  output logic [1:0] fwd
);
  // R15 is the PC; its writes never go through the bypass network.
  always_comb begin
    fwd = 2'b00;
    if (ex_mem_reg_write && (ex_mem_wa != 4'hF) && (ex_mem_wa == ra))
      fwd = 2'b10;
    else if (mem_wb_reg_write && (mem_wb_wa != 4'hF) && (mem_wb_wa == ra))
      fwd = 2'b01;
  end
endmodule

module hazard_ctrl #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] if_id_ra1,
  input  logic [3:0] if_id_ra2,
  input  logic [3:0] id_ex_ra1,
  input  logic [3:0] id_ex_ra2,
  input  logic [3:0] id_ex_wa,
  input  logic       id_ex_reg_write,
  input  logic       id_ex_mem_to_reg,
  input  logic [3:0] ex_mem_wa,
  input  logic       ex_mem_reg_write,
  input  logic [3:0] mem_wb_wa,
  input  logic       mem_wb_reg_write,
  input  logic       branch_taken,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       pc_enable,
  output logic       if_id_enable,
  output logic       id_ex_enable,
  output logic       ex_mem_enable,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic       mem_wb_bubble,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic [1:0] state,
  output logic       mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);
  localparam int         NUM_OPS = 2;
  localparam logic [7:0] WAIT_LIM8 = 8'(WAIT_LIMIT);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    FLUSH    = 2'b10,
    MEM_WAIT = 2'b11
  } act_e;

  act_e       act, state_q;
  logic       lu_hazard;
  logic [7:0] wait_cnt, wait_nxt;
  logic       timeout_q;

  logic [NUM_OPS-1:0][3:0] op_ra;
  logic [NUM_OPS-1:0][1:0] op_fwd;

  assign op_ra = {id_ex_ra2, id_ex_ra1};

  generate
    for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
      hazard_fwd_sel u_fwd (
        .ra               (op_ra[g]),
        .ex_mem_wa        (ex_mem_wa),
        .ex_mem_reg_write (ex_mem_reg_write),
        .mem_wb_wa        (mem_wb_wa),
        .mem_wb_reg_write (mem_wb_reg_write),
        .fwd              (op_fwd[g])
      );
    end
  endgenerate

  // Outputs idle at RUN / register-file operands while reset is held.
  assign fwd_a = reset ? op_fwd[0] : 2'b00;
  assign fwd_b = reset ? op_fwd[1] : 2'b00;

  assign lu_hazard = id_ex_mem_to_reg && id_ex_reg_write && (id_ex_wa != 4'hF) &&
                     ((id_ex_wa == if_id_ra1) || (id_ex_wa == if_id_ra2));

  always_ff @(posedge clk) begin
    if (!reset) state_q <= RUN;
    else        state_q <= act;
  end

  always_comb begin
    act           = RUN;
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    id_ex_enable  = 1'b1;
    ex_mem_enable = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    mem_wb_bubble = 1'b0;
    // A branch seen during a wait stays frozen in EX and wins once memory is ready.
    if (reset) begin
      if (dmem_req && !dmem_ready) act = MEM_WAIT;
      else if (branch_taken)       act = FLUSH;
      else if (lu_hazard)          act = LU_STALL;
    end
    case (act)
      MEM_WAIT: begin
        pc_enable     = 1'b0;
        if_id_enable  = 1'b0;
        id_ex_enable  = 1'b0;
        ex_mem_enable = 1'b0;
        mem_wb_bubble = 1'b1;
      end
      FLUSH: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end
      LU_STALL: begin
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = state_q;

  always_comb begin
    wait_nxt = 8'h00;
    if (act == MEM_WAIT)
      wait_nxt = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'h01;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt  <= 8'h00;
      timeout_q <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      if ((act == MEM_WAIT) && (wait_nxt == WAIT_LIM8)) timeout_q <= 1'b1;
    end
  end

  assign mem_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= 16'h0000;
      flush_q <= 16'h0000;
    end else begin
      if (((act == LU_STALL) || (act == MEM_WAIT)) && (stall_q != 16'hFFFF))
        stall_q <= stall_q + 16'h0001;
      if ((act == FLUSH) && (flush_q != 16'hFFFF))
        flush_q <= flush_q + 16'h0001;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter WAIT_LIMIT, 15, maximum consecutive memory-wait cycles before a timeout is flagged (range 1..255).
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 if_id_ra1, if_id_ra2  in  4 each  source registers of the instruction in ID (Instr[19:16], Instr[3:0]).
REQ-005 id_ex_ra1, id_ex_ra2  in  4 each  source registers of the instruction in EX.
REQ-006 id_ex_wa  in  4, id_ex_reg_write  in  1, id_ex_mem_to_reg  in  1  EX-stage destination and load indication.
REQ-007 ex_mem_wa  in  4, ex_mem_reg_write  in  1; mem_wb_wa  in  4, mem_wb_reg_write  in  1  later-stage destinations.
REQ-008 branch_taken  in  1  branch in EX resolved taken this cycle.
REQ-009 dmem_req  in  1, dmem_ready  in  1  data-memory access handshake in MEM.
REQ-010 pc_enable, if_id_enable, id_ex_enable, ex_mem_enable  out  1 each  pipeline register enables.
REQ-011 if_id_flush  out  1  clear IF/ID to NOP; id_ex_bubble  out  1  select zeroed controls in the control mux; mem_wb_bubble  out  1  insert bubble into MEM/WB.
REQ-012 fwd_a, fwd_b  out  2 each  ALU operand source: 00 register file, 10 EX/MEM result, 01 MEM/WB result.
REQ-013 state  out  2  action taken in previous cycle: 00 RUN, 01 LU_STALL, 10 FLUSH, 11 MEM_WAIT.
REQ-014 mem_timeout  out  1  sticky wait-limit violation flag.

Function
REQ-015 Each cycle selects one action, in priority order MEM_WAIT > FLUSH > LU_STALL > RUN; action outputs are combinational from the current inputs.
REQ-016 MEM_WAIT when dmem_req=1 and dmem_ready=0: all four enables 0, mem_wb_bubble=1, flush/bubble 0.
REQ-017 FLUSH when branch_taken=1 and not MEM_WAIT: all enables 1, if_id_flush=1, id_ex_bubble=1.
REQ-018 LU_STALL when id_ex_mem_to_reg=1, id_ex_reg_write=1 and id_ex_wa equals if_id_ra1 or if_id_ra2, and no higher-priority action: pc_enable=0, if_id_enable=0, id_ex_bubble=1, other enables 1.
REQ-019 RUN otherwise: all enables 1, if_id_flush, id_ex_bubble and mem_wb_bubble 0.
REQ-020 Branch during MEM_WAIT stays frozen in EX and is acted on in the first non-wait cycle; a load-use hazard coincident with branch_taken is discarded.
REQ-021 fwd_a=10 when ex_mem_reg_write=1 and ex_mem_wa==id_ex_ra1; else 01 when mem_wb_reg_write=1 and mem_wb_wa==id_ex_ra1; else 00. fwd_b uses id_ex_ra2 identically; EX/MEM has priority.
REQ-022 Writes to R15 (wa=4'hF) are never forwarded and never raise LU_STALL.
REQ-023 state register loads the selected action code every rising edge.
REQ-024 An 8-bit wait counter increments each MEM_WAIT cycle, saturating at 255, and clears on any non-MEM_WAIT cycle.
REQ-025 mem_timeout sets at the edge where the wait counter reaches WAIT_LIMIT and stays 1 until reset.
REQ-026 LU_STALL in two consecutive cycles without intervening MEM_WAIT is illegal; the bench flags it as an assertion failure.

Reset
REQ-027 While reset=0 at a rising edge: state=00, wait counter=0, mem_timeout=0, counters (REQ-029) cleared.
REQ-028 Reset has priority over all inputs; reset asserted mid-MEM_WAIT or mid-stall returns state to RUN at that edge, and combinational outputs follow inputs only after reset release.

Configuration
REQ-029 With HAZARD_PERF_CNT_EN defined: outputs stall_cycles (16) and flush_count (16) exist; stall_cycles increments on every LU_STALL or MEM_WAIT cycle, flush_count on every FLUSH cycle, both saturating at 16'hFFFF.
REQ-030 Without HAZARD_PERF_CNT_EN: those ports and counters are absent; all other behaviour is identical.

Verification
REQ-031 LDR R2 in EX (id_ex_wa=2, mem_to_reg=1), ID reads R2 -> one cycle pc_enable=0, if_id_enable=0, id_ex_bubble=1; next state=01; following cycle RUN.
REQ-032 ex_mem_wa=5 and mem_wb_wa=5 both writing, id_ex_ra1=5 -> fwd_a=10; ex_mem_reg_write=0 -> fwd_a=01; ex_mem_wa=15 with id_ex_ra2=15 -> fwd_b=00.
REQ-033 branch_taken=1 together with load-use hazard -> if_id_flush=1, id_ex_bubble=1, pc_enable=1; state=10.
REQ-034 dmem_ready=0 for 15 cycles with WAIT_LIMIT=15 -> all enables 0 throughout; mem_timeout=1 after the 15th edge and stays 1 after dmem_ready=1.
REQ-035 reset=0 during MEM_WAIT -> state=00, mem_timeout=0, wait counter 0 after the edge; with HAZARD_PERF_CNT_EN, stall_cycles=0.
